rr_ex_stage: RTL
================

Name: rr_ex_stage

Overview:
- Register-read stage that sits directly downstream of the ID/RR pipeline register. Consumes its decoded fields and control bits.
- Holds the 32-entry register file, with a write-back write port and write-through bypass.
- Detects load-use hazards and drives the stall back into the ID/RR register.
- Captures operands, destination and control into the RR/EX pipeline register, which supports hold and flush.

Parameters:
- DATA_W, 32, register/operand width.
- NUM_REGS, 32, register file depth; address width fixed at 5; entry 0 reads as zero.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset is synchronous and active-high.
- rs_id_rr, rt_id_rr, rd_id_rr  in  5 each  register specifiers from ID/RR.
- shamt_id_rr  in  5  shift amount.
- funct_id_rr  in  6  function code.
- extended_id_rr  in  DATA_W  sign-extended immediate.
- RegDst_id_rr, jump_id_rr, MemRead_id_rr, MemWrite_id_rr, ALUSrc_id_rr, MemtoReg_id_rr, RegWrite_id_rr  in  1 each  control from ID/RR.
- ALUOp_id_rr  in  2  ALU op class.
- wb_we  in  1  write-back enable.
- wb_addr  in  5  write-back register.
- wb_data  in  DATA_W  write-back data.
- hold  in  1  downstream freeze (memory wait).
- flush  in  1  squash from EX (taken branch/jump).
- stall_out  out  1  to ID/RR stall input; ID/RR keeps its contents while high.
- rs_val_rr_ex, rt_val_rr_ex  out  DATA_W  operand values.
- rs_rr_ex, rt_rr_ex  out  5  specifiers, used for forwarding.
- dest_rr_ex  out  5  destination: rd if RegDst else rt.
- shamt_rr_ex  out  5.
- funct_rr_ex  out  6.
- extended_rr_ex  out  DATA_W.
- jump_rr_ex, MemRead_rr_ex, MemWrite_rr_ex, ALUSrc_rr_ex, MemtoReg_rr_ex, RegWrite_rr_ex  out  1 each.
- ALUOp_rr_ex  out  2.

Behaviour:
- Register file:
  - On a clock edge with reset high, all entries clear to 0.
  - Otherwise, when wb_we=1 and wb_addr!=0, entry[wb_addr] <= wb_data at posedge.
  - Writes to entry 0 are ignored. Writes happen regardless of hold, flush and stall.
- Read:
  - Combinational. Specifier 0 returns 0.
  - If wb_we=1 and wb_addr equals a nonzero specifier, return wb_data (same-cycle write-through bypass).
- Load-use detect (combinational): load_use = MemRead_rr_ex & (dest_rr_ex!=0) & (dest_rr_ex==rs_id_rr | dest_rr_ex==rt_id_rr).
- stall_out = (load_use | hold) & ~flush.
- RR/EX register update at posedge, priority highest first:
  1. reset: all outputs 0.
  2. flush: all control outputs 0 (bubble); data fields 0.
  3. hold: all outputs keep their values.
  4. load_use: control outputs 0 (bubble); data fields may update but are don't-care.
  5. normal: capture read values, mux dest, copy all fields and control.
- Latency: one cycle from ID/RR contents to RR/EX outputs.
- A load-use stall lasts exactly one cycle. The next cycle the RR/EX entry is a bubble (MemRead_rr_ex=0), so load_use falls.
- Reset values: every output, including stall_out, is 0 in the cycle after reset is sampled. Reset asserted mid-stall or mid-hold clears everything the next edge, and stall_out drops.
- flush and hold together: flush wins and the bubble is inserted. stall_out=0 that cycle, so ID/RR loads the fetch-side squashed instruction.
- flush and load_use together: flush wins, stall_out=0.
- The write-back to a register read in the same cycle is seen via the bypass. A write landing during hold is visible once hold drops, because values are re-read from the file.
- Unused-operand false stalls are accepted; rt match triggers even for I-type. This is a decided simplification.

Test Plan:
- Reset/write-read: reset=1 one edge → all outputs 0. Then wb_we=1, wb_addr=5, wb_data=0x1234_5678; next cycle rs_id_rr=5 → rs_val_rr_ex=0x12345678 after one edge.
- Zero register and bypass:
  - wb write to addr 0 with 0xFFFF_FFFF, read rs=0 → 0.
  - Same cycle wb_we=1, wb_addr=7, wb_data=0xA5A5_A5A5 with rt_id_rr=7 → rt_val_rr_ex=0xA5A5A5A5 next edge.
- Load-use: RR/EX holds MemRead=1, dest=9; ID/RR has rs=9 → stall_out=1 for exactly one cycle. Next RR/EX has all control 0. Following cycle captures the rs=9 instruction; stall_out=0 throughout.
- Hold: hold=1 for 3 cycles with changing ID/RR inputs → RR/EX outputs unchanged and stall_out=1. On release, capture the current ID/RR contents.
- Flush priority: flush=1 with hold=1 and load_use true → next edge all RR/EX controls 0; stall_out=0 in that cycle.
- Destination mux and reset mid-operation:
  - RegDst=1, rd=12, rt=3 → dest_rr_ex=12; with RegDst=0 → 3.
  - Assert reset while stall_out=1 → next edge all outputs 0 and the register file is cleared (read r5 → 0).

Source files
------------

// File: rtl/rr_ex_stage.sv
// rr_ex_stage: register-read stage between the ID/RR and RR/EX pipeline registers.
//
// Holds the 32-entry register file (entry 0 hard-wired to zero) with one write-back
// port and same-cycle write-through bypass on both read ports. Detects load-use
// hazards against the instruction currently in RR/EX and stalls ID/RR. Captures
// operands, destination, decoded fields and control into the RR/EX register, which
// supports hold (downstream freeze) and flush (squash to a bubble).
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   *_id_rr                        decoded fields and control from ID/RR
//   wb_we, wb_addr, wb_data        register-file write-back port
//   hold, flush                    RR/EX freeze and squash requests
//   stall_out                      stall request back to ID/RR
//   *_rr_ex                        RR/EX pipeline register contents
module rr_ex_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        rs_id_rr,
  input  logic [4:0]        rt_id_rr,
  input  logic [4:0]        rd_id_rr,
  input  logic [4:0]        shamt_id_rr,
  input  logic [5:0]        funct_id_rr,
  input  logic [DATA_W-1:0] extended_id_rr,
  input  logic              RegDst_id_rr,
  input  logic              jump_id_rr,
  input  logic              MemRead_id_rr,
  input  logic              MemWrite_id_rr,
  input  logic              ALUSrc_id_rr,
  input  logic              MemtoReg_id_rr,
  input  logic              RegWrite_id_rr,
  input  logic [1:0]        ALUOp_id_rr,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              hold,
  input  logic              flush,
  output logic              stall_out,
  output logic [DATA_W-1:0] rs_val_rr_ex,
  output logic [DATA_W-1:0] rt_val_rr_ex,
  output logic [4:0]        rs_rr_ex,
  output logic [4:0]        rt_rr_ex,
  output logic [4:0]        dest_rr_ex,
  output logic [4:0]        shamt_rr_ex,
  output logic [5:0]        funct_rr_ex,
  output logic [DATA_W-1:0] extended_rr_ex,
  output logic              jump_rr_ex,
  output logic              MemRead_rr_ex,
  output logic              MemWrite_rr_ex,
  output logic              ALUSrc_rr_ex,
  output logic              MemtoReg_rr_ex,
  output logic              RegWrite_rr_ex,
  output logic [1:0]        ALUOp_rr_ex
);

  // Control bundle layout: {jump, MemRead, MemWrite, ALUSrc, MemtoReg, RegWrite, ALUOp}
  localparam int unsigned CtrlW = 8;

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic [CtrlW-1:0]  r_ctrl;
  logic [DATA_W-1:0] r_rs_val;
  logic [DATA_W-1:0] r_rt_val;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_dest;
  logic [4:0]        r_shamt;
  logic [5:0]        r_funct;
  logic [DATA_W-1:0] r_ext;

  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic [CtrlW-1:0]  w_ctrl_in;
  logic [4:0]        w_dest_in;
  logic              w_load_use;

  // Register file: write-back lands regardless of hold/flush/stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wb_we && (wb_addr != 5'd0)) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Reads: zero register, then write-through bypass, then the stored entry.
  always_comb begin
    w_rs_val = r_regs[rs_id_rr];
    if (rs_id_rr == 5'd0) begin
      w_rs_val = '0;
    end else if (wb_we && (wb_addr == rs_id_rr)) begin
      w_rs_val = wb_data;
    end

    w_rt_val = r_regs[rt_id_rr];
    if (rt_id_rr == 5'd0) begin
      w_rt_val = '0;
    end else if (wb_we && (wb_addr == rt_id_rr)) begin
      w_rt_val = wb_data;
    end
  end

  assign w_ctrl_in = {jump_id_rr, MemRead_id_rr, MemWrite_id_rr, ALUSrc_id_rr,
                      MemtoReg_id_rr, RegWrite_id_rr, ALUOp_id_rr};
  assign w_dest_in = RegDst_id_rr ? rd_id_rr : rt_id_rr;

  // rt is compared even for I-type consumers; the occasional false stall is accepted.
  assign w_load_use = r_ctrl[6] && (r_dest != 5'd0) &&
                      ((r_dest == rs_id_rr) || (r_dest == rt_id_rr));

  assign stall_out = (w_load_use || hold) && !flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_ctrl   <= '0;
      r_rs_val <= '0;
      r_rt_val <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_dest   <= '0;
      r_shamt  <= '0;
      r_funct  <= '0;
      r_ext    <= '0;
    end else if (!hold) begin
      // A load-use bubble only needs dead control; data fields are don't-care.
      r_ctrl   <= w_load_use ? '0 : w_ctrl_in;
      r_rs_val <= w_rs_val;
      r_rt_val <= w_rt_val;
      r_rs     <= rs_id_rr;
      r_rt     <= rt_id_rr;
      r_dest   <= w_dest_in;
      r_shamt  <= shamt_id_rr;
      r_funct  <= funct_id_rr;
      r_ext    <= extended_id_rr;
    end
  end

  assign rs_val_rr_ex   = r_rs_val;
  assign rt_val_rr_ex   = r_rt_val;
  assign rs_rr_ex       = r_rs;
  assign rt_rr_ex       = r_rt;
  assign dest_rr_ex     = r_dest;
  assign shamt_rr_ex    = r_shamt;
  assign funct_rr_ex    = r_funct;
  assign extended_rr_ex = r_ext;
  assign jump_rr_ex     = r_ctrl[7];
  assign MemRead_rr_ex  = r_ctrl[6];
  assign MemWrite_rr_ex = r_ctrl[5];
  assign ALUSrc_rr_ex   = r_ctrl[4];
  assign MemtoReg_rr_ex = r_ctrl[3];
  assign RegWrite_rr_ex = r_ctrl[2];
  assign ALUOp_rr_ex    = r_ctrl[1:0];

endmodule
